// File: rtl/lagarto_fpu_pkg.sv
// Shared Lagarto vector FPU types: conversion-unit interface structs,
// IEEE status flags and the widening-sequencer state encoding.
package lagarto_fpu_pkg;

    // IEEE-754 exception flags in RISC-V fflags order (NV DZ OF UF NX)
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_status_flags;

    // Operands presented to a shared FPU functional unit
    typedef struct packed {
        logic [63:0] operand_a;
        logic [63:0] operand_b;
        logic [2:0]  rm;
        logic        op_valid;
    } unit_input_t;

    // Combinational result returned by a functional unit
    typedef struct packed {
        logic [63:0]    result;
        fp_status_flags status;
    } unit_output_t;

    // Widening SP->DP sequencer control states
    typedef enum logic [2:0] {
        FWS_IDLE  = 3'd0,
        FWS_FETCH = 3'd1,
        FWS_LO    = 3'd2,
        FWS_HI    = 3'd3,
        FWS_DONE  = 3'd4
    } fp_widen_seq_state_t;

endpackage

// File: rtl/fp_widen_sequencer.sv
// Streams a vector of packed SP elements through one shared SP->DP
// conversion unit, one element per cycle, and emits a completion beat
// carrying the sticky OR of all element status flags.
module fp_widen_sequencer
    import lagarto_fpu_pkg::*;
#(
    parameter int MAX_VL = 32,
    parameter int TAG_W  = 5,
    parameter int VL_W   = $clog2(MAX_VL + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [VL_W-1:0]      req_vl_i,
    input  logic [TAG_W-1:0]     req_tag_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [63:0]          src_data_i,
    output unit_input_t          cvt_input_o,
    input  unit_output_t         cvt_output_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [63:0]          res_data_o,
    output logic [VL_W-1:0]      res_idx_o,
    output logic                 res_last_o,
    output logic                 done_valid_o,
    output logic [TAG_W-1:0]     done_tag_o,
    output fp_status_flags       done_status_o,
    output logic                 busy_o
);

    fp_widen_seq_state_t state_q, state_d;

    logic [VL_W-1:0]  vl_q;
    logic [VL_W-1:0]  idx_q;
    logic [TAG_W-1:0] tag_q;
    fp_status_flags   status_q;
    logic [63:0]      word_q;

    logic             res_valid_q;
    logic [63:0]      res_data_q;
    logic [VL_W-1:0]  res_idx_q;
    logic             res_last_q;

    logic             out_free;
    logic             last_elem;
    logic             converting;
    logic             req_fire;
    logic             src_ready;
    logic             src_fire;
    logic             load;
    logic             done_fire;
    logic [VL_W-1:0]  vl_clamped;

    assign vl_clamped = (req_vl_i > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : req_vl_i;
    assign out_free   = !res_valid_q || res_ready_i;
    assign last_elem  = (idx_q == (vl_q - VL_W'(1)));
    assign converting = (state_q == FWS_LO) || (state_q == FWS_HI);
    assign req_fire   = req_valid_i && (state_q == FWS_IDLE);
    assign src_fire   = src_valid_i && src_ready;
    assign load       = converting && out_free;
    // The output register only ever holds the final result while in DONE
    assign done_fire  = (state_q == FWS_DONE) &&
                        (!res_valid_q || (res_ready_i && res_last_q));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FWS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FWS_IDLE: begin
                if (req_valid_i) begin
                    state_d = (vl_clamped != '0) ? FWS_FETCH : FWS_DONE;
                end
            end
            FWS_FETCH: begin
                if (src_valid_i) begin
                    state_d = FWS_LO;
                end
            end
            FWS_LO: begin
                if (out_free) begin
                    state_d = last_elem ? FWS_DONE : FWS_HI;
                end
            end
            FWS_HI: begin
                if (out_free) begin
                    if (last_elem) begin
                        state_d = FWS_DONE;
                    end else begin
                        state_d = src_valid_i ? FWS_LO : FWS_FETCH;
                    end
                end
            end
            FWS_DONE: begin
                if (done_fire) begin
                    state_d = FWS_IDLE;
                end
            end
            default: state_d = FWS_IDLE;
        endcase
    end

    // Output decode: handshakes, conversion-unit drive, completion beat
    always_comb begin
        req_ready_o  = (state_q == FWS_IDLE);
        src_ready    = (state_q == FWS_FETCH) ||
                       ((state_q == FWS_HI) && out_free && !last_elem);
        busy_o       = (state_q != FWS_IDLE);
        done_valid_o = done_fire;
        cvt_input_o  = '0;
        if (state_q == FWS_LO) begin
            cvt_input_o.op_valid  = 1'b1;
            cvt_input_o.operand_a = {32'b0, word_q[31:0]};
        end else if (state_q == FWS_HI) begin
            cvt_input_o.op_valid  = 1'b1;
            cvt_input_o.operand_a = {32'b0, word_q[63:32]};
        end
    end

    assign src_ready_o = src_ready;

    // Request context, source word and sticky status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vl_q     <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
            status_q <= '0;
            word_q   <= '0;
        end else begin
            if (req_fire) begin
                vl_q     <= vl_clamped;
                tag_q    <= req_tag_i;
                idx_q    <= '0;
                status_q <= '0;
            end
            if (src_fire) begin
                word_q <= src_data_i;
            end
            if (load) begin
                status_q <= status_q | cvt_output_i.status;
                idx_q    <= idx_q + VL_W'(1);
            end
        end
    end

    // res_stage: valid/ready output register, reload wins over drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
        end else if (load) begin
            res_valid_q <= 1'b1;
            res_data_q  <= cvt_output_i.result;
            res_idx_q   <= idx_q;
            res_last_q  <= last_elem;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_idx_o     = res_idx_q;
    assign res_last_o    = res_last_q;
    assign done_tag_o    = tag_q;
    assign done_status_o = status_q;

endmodule

// File: tb/tb_fp_widen_sequencer.sv
// Scoreboard bench for fp_widen_sequencer with a behavioural SP->DP
// conversion unit attached to the shared-unit port.
module tb_fp_widen_sequencer;
    import lagarto_fpu_pkg::*;

    localparam int MAX_VL = 32;
    localparam int TAG_W  = 5;
    localparam int VL_W   = $clog2(MAX_VL + 1);

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [VL_W-1:0]    req_vl_i = '0;
    logic [TAG_W-1:0]   req_tag_i = '0;
    logic               src_valid_i = 1'b0;
    logic               src_ready_o;
    logic [63:0]        src_data_i = '0;
    unit_input_t        cvt_input_o;
    unit_output_t       cvt_output_i;
    logic               res_valid_o;
    logic               res_ready_i = 1'b1;
    logic [63:0]        res_data_o;
    logic [VL_W-1:0]    res_idx_o;
    logic               res_last_o;
    logic               done_valid_o;
    logic [TAG_W-1:0]   done_tag_o;
    fp_status_flags     done_status_o;
    logic               busy_o;

    fp_widen_sequencer #(.MAX_VL(MAX_VL), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_vl_i(req_vl_i), .req_tag_i(req_tag_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
        .cvt_input_o(cvt_input_o), .cvt_output_i(cvt_output_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_idx_o(res_idx_o), .res_last_o(res_last_o),
        .done_valid_o(done_valid_o), .done_tag_o(done_tag_o),
        .done_status_o(done_status_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural conversion unit: exact SP->DP widening, sNaN raises NV
    function automatic unit_output_t sp2dp(input logic [31:0] f);
        unit_output_t o;
        logic [22:0]  m;
        int           sh;
        o = '0;
        m = f[22:0];
        if (f[30:23] == 8'hFF) begin
            if (m == '0) begin
                o.result = {f[31], 11'h7FF, 52'b0};
            end else begin
                o.result = 64'h7FF8000000000000;
                o.status.nv = !m[22];
            end
        end else if (f[30:23] == 8'h00) begin
            if (m == '0) begin
                o.result = {f[31], 63'b0};
            end else begin
                sh = 0;
                while (!m[22]) begin
                    m = m << 1;
                    sh++;
                end
                m = m << 1;
                o.result = {f[31], 11'(896 - sh), m, 29'b0};
            end
        end else begin
            o.result = {f[31], 11'({3'b0, f[30:23]} + 11'd896), m, 29'b0};
        end
        return o;
    endfunction

    always_comb begin
        cvt_output_i = '0;
        if (cvt_input_o.op_valid) begin
            cvt_output_i = sp2dp(cvt_input_o.operand_a[31:0]);
        end
    end

    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
    } res_exp_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       st;
    } done_exp_t;

    res_exp_t    res_q[$];
    done_exp_t   done_q[$];
    logic [63:0] src_q[$];
    logic [63:0] words[$];
    logic [63:0] exps[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor-side measurements, reset by the stimulus before each request
    int max_run       = 0;
    int run_len       = 0;
    int first_res_cyc = -1;
    int done_cyc      = -1;
    int done_seen     = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [VL_W-1:0] prev_idx;

    // Monitor: pops the scoreboard on every result or done beat
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (res_valid_o) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (first_res_cyc < 0) first_res_cyc = cyc;
            end else begin
                run_len = 0;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(res_valid_o), 64'd1);
                check("hold_data", res_data_o, prev_data);
                check("hold_idx", 64'(res_idx_o), 64'(prev_idx));
            end
            prev_stall = res_valid_o && !res_ready_i;
            prev_data  = res_data_o;
            prev_idx   = res_idx_o;
            if (res_valid_o && res_ready_i) begin
                if (res_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got idx %0d data %h expected none", res_idx_o, res_data_o);
                end else begin
                    res_exp_t e;
                    e = res_q.pop_front();
                    $display("result idx=%0d data=%h last=%0d (exp %h)", res_idx_o, res_data_o, res_last_o, e.data);
                    check("res_data", res_data_o, e.data);
                    check("res_idx", 64'(res_idx_o), 64'(e.idx));
                    check("res_last", 64'(res_last_o), 64'(e.last));
                end
            end
            if (done_valid_o) begin
                done_seen++;
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got tag %h expected none", done_tag_o);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    $display("done tag=%h status=%b (exp tag %h status %b)", done_tag_o, done_status_o, d.tag, d.st);
                    check("done_tag", 64'(done_tag_o), 64'(d.tag));
                    check("done_status", 64'(done_status_o), 64'(d.st));
                    check("results_before_done", 64'(res_q.size()), 64'd0);
                end
            end
        end
    end

    // Stimulus-side handshake bookkeeping
    bit s_fire, r_fire, src_en;
    bit srdy_now;
    logic [63:0] op_now;
    bit op_valid_now;
    int first_src_cyc  = -1;
    int first_srdy_cyc = -1;
    int req_cyc        = -1;

    // One cycle: sample handshakes at negedge, update inputs after posedge
    task automatic tick();
        @(negedge clk_i);
        s_fire       = src_valid_i && src_ready_o;
        r_fire       = req_valid_i && req_ready_o;
        srdy_now     = src_ready_o;
        op_valid_now = cvt_input_o.op_valid;
        op_now       = cvt_input_o.operand_a;
        if (s_fire && first_src_cyc < 0) first_src_cyc = cyc;
        if (src_ready_o && first_srdy_cyc < 0) first_srdy_cyc = cyc;
        if (r_fire) req_cyc = cyc;
        @(posedge clk_i);
        #1;
        if (s_fire && src_q.size() > 0) void'(src_q.pop_front());
        src_valid_i = src_en && (src_q.size() > 0);
        src_data_i  = (src_q.size() > 0) ? src_q[0] : 64'd0;
        if (r_fire) req_valid_i = 1'b0;
    endtask

    task automatic start_req(input int vl, input logic [TAG_W-1:0] tag);
        max_run        = 0;
        first_res_cyc  = -1;
        first_src_cyc  = -1;
        first_srdy_cyc = -1;
        req_cyc        = -1;
        done_seen      = 0;
        src_q          = words;
        src_en         = 1'b1;
        src_valid_i    = (src_q.size() > 0);
        src_data_i     = (src_q.size() > 0) ? src_q[0] : 64'd0;
        req_valid_i    = 1'b1;
        req_vl_i       = VL_W'(vl);
        req_tag_i      = tag;
    endtask

    // Issue one request, push its expectations, and run until the done beat
    task automatic run_req(input int vl, input logic [TAG_W-1:0] tag, input logic [4:0] st,
                           input int stall_at, input int stall_len);
        int n;
        int k;
        bit stalled;
        done_exp_t d;
        n = (vl > MAX_VL) ? MAX_VL : vl;
        for (int i = 0; i < n; i++) begin
            res_exp_t e;
            e.data = exps[i];
            e.idx  = i;
            e.last = (i == n - 1);
            res_q.push_back(e);
        end
        d.tag = tag;
        d.st  = st;
        done_q.push_back(d);
        start_req(vl, tag);
        k = 0;
        while (done_seen == 0 && k < 400) begin
            stalled     = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
            res_ready_i = !stalled;
            tick();
            if (stalled) check("src_ready_during_stall", 64'(srdy_now), 64'd0);
            k++;
        end
        if (done_seen == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done beat expected tag %h", tag);
        end
        res_ready_i = 1'b1;
        src_en      = 1'b0;
        repeat (3) tick();
        check("single_done", 64'(done_seen), 64'd1);
        check("results_drained", 64'(res_q.size()), 64'd0);
        check("words_consumed", 64'(src_q.size()), 64'd0);
        check("idle_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_src_ready", 64'(src_ready_o), 64'd0);
        check("rst_done", 64'(done_valid_o), 64'd0);
        check("rst_res_data", res_data_o, 64'd0);
        check("rst_op_valid", 64'(cvt_input_o.op_valid), 64'd0);
        @(posedge clk_i);
        #1;

        // vl=4 basic stream
        words = '{64'h40000000_3F800000, 64'hC0400000_00000000};
        exps  = '{64'h3FF0000000000000, 64'h4000000000000000,
                  64'h0000000000000000, 64'hC008000000000000};
        run_req(4, 5'h0A, 5'b00000, 0, 0);
        check("vl4_consecutive_valid", 64'(max_run), 64'd4);
        check("vl4_src_to_res_latency", 64'(first_res_cyc - first_src_cyc), 64'd2);
        check("vl4_req_to_src_ready", 64'(first_srdy_cyc - req_cyc), 64'd1);

        // vl=3: upper half of word 1 is an sNaN and must never be converted
        words = '{64'h40000000_3F800000, 64'h7F800001_C0400000};
        exps  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'hC008000000000000};
        run_req(3, 5'h03, 5'b00000, 0, 0);

        // vl=0: immediate completion, no source traffic
        words = {};
        exps  = {};
        run_req(0, 5'h1F, 5'b00000, 0, 0);
        check("vl0_done_latency", 64'(done_cyc - req_cyc), 64'd1);
        check("vl0_no_src_ready", 64'(first_srdy_cyc), 64'hFFFFFFFF_FFFFFFFF);

        // vl=6 with a 5-cycle downstream stall mid-stream
        words = '{64'h40400000_3F000000, 64'h41200000_BF800000, 64'h7F800000_42C80000};
        exps  = '{64'h3FE0000000000000, 64'h4008000000000000, 64'hBFF0000000000000,
                  64'h4024000000000000, 64'h4059000000000000, 64'h7FF0000000000000};
        run_req(6, 5'h11, 5'b00000, 4, 5);

        // sNaN element: invalid flag propagates to done status
        words = '{64'h3F800000_7F800001};
        exps  = '{64'h7FF8000000000000, 64'h3FF0000000000000};
        run_req(2, 5'h07, 5'b10000, 0, 0);

        // vl above MAX_VL is clamped to MAX_VL
        words = {};
        exps  = {};
        for (int i = 0; i < MAX_VL / 2; i++) begin
            words.push_back(64'h3F800000_40000000);
            exps.push_back(64'h4000000000000000);
            exps.push_back(64'h3FF0000000000000);
        end
        run_req(40, 5'h15, 5'b00000, 0, 0);

        // Reset while in HI: request abandoned, no done beat
        words = '{64'h40000000_3F800000, 64'hC0400000_00000000};
        start_req(4, 5'h09);
        begin
            int k;
            k = 0;
            op_valid_now = 1'b0;
            op_now       = '0;
            while (!(op_valid_now && op_now == 64'h3F800000) && k < 50) begin
                tick();
                k++;
            end
            check("reached_lo_before_reset", 64'(op_valid_now && op_now == 64'h3F800000), 64'd1);
        end
        // the DUT is now in HI; reset is sampled on the next edge
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        src_en      = 1'b0;
        src_q.delete();
        src_valid_i = 1'b0;
        req_valid_i = 1'b0;
        res_q.delete();
        done_q.delete();
        done_seen = 0;
        @(negedge clk_i);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_res_valid", 64'(res_valid_o), 64'd0);
        check("midrst_done", 64'(done_valid_o), 64'd0);
        check("midrst_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        repeat (3) tick();
        check("midrst_no_done", 64'(done_seen), 64'd0);

        // Normal request after the abandoned one
        words = '{64'hC0400000_40000000};
        exps  = '{64'h4000000000000000, 64'hC008000000000000};
        run_req(2, 5'h02, 5'b00000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
